// File: rtl/hazard_control_pkg.sv
// hazard_control_pkg: shared pipeline stage-control types
package hazard_control_pkg;
  localparam int REG_IDX_W = 5;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, FLUSH = 2'd2, MEM_WAIT = 2'd3} hc_state_e;
  typedef struct packed {
    logic fetch_enable;
    logic decode_enable;
    logic decode_stall_control;
    logic id_flush;
    logic ex_bubble;
    logic ex_hold;
  } stage_ctrl_t;
  localparam stage_ctrl_t CTRL_RUN   = 6'b110000;
  localparam stage_ctrl_t CTRL_LU    = 6'b001010;
  localparam stage_ctrl_t CTRL_FLUSH = 6'b100110;
  localparam stage_ctrl_t CTRL_MEM   = 6'b001001;
endpackage

// File: rtl/hazard_control_if.sv
// hazard_control_if: pipeline hazard status in, stage controls out
interface hazard_control_if;
  import hazard_control_pkg::*;
  logic id_valid, id_uses_rs1, id_uses_rs2;
  reg_idx_t id_rs1, id_rs2;
  logic ex_valid, ex_is_load;
  reg_idx_t ex_rd;
  logic ex_branch_taken;
  logic dmem_req, dmem_ready;
  logic fetch_enable, decode_enable, decode_stall_control;
  logic id_flush, ex_bubble, ex_hold;
  modport master (
    output id_valid, id_uses_rs1, id_uses_rs2, id_rs1, id_rs2,
           ex_valid, ex_is_load, ex_rd, ex_branch_taken, dmem_req, dmem_ready,
    input  fetch_enable, decode_enable, decode_stall_control, id_flush, ex_bubble, ex_hold
  );
  modport slave (
    input  id_valid, id_uses_rs1, id_uses_rs2, id_rs1, id_rs2,
           ex_valid, ex_is_load, ex_rd, ex_branch_taken, dmem_req, dmem_ready,
    output fetch_enable, decode_enable, decode_stall_control, id_flush, ex_bubble, ex_hold
  );
endinterface

// File: rtl/hazard_control.sv
// hazard_control: load-use / branch / memory-wait pipeline control FSM with stall counter
module hazard_control
  import hazard_control_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  hazard_control_if.slave        bus,
  input  logic                   stall_cnt_clr,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_count
);
  hc_state_e st, nxt;
  stage_ctrl_t ctrl;
  logic lu_hazard, mem_wait;
  assign lu_hazard = bus.id_valid & bus.ex_valid & bus.ex_is_load & (bus.ex_rd != '0) &
                     ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                      (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));
  assign mem_wait = bus.dmem_req & ~bus.dmem_ready;
  // Event priority: memory wait, then MEM_WAIT exit, FLUSH, branch, load-use
  always_comb begin
    ctrl = CTRL_RUN;
    nxt = RUN;
    if (mem_wait) begin
      ctrl = CTRL_MEM;
      nxt = MEM_WAIT;
    end else if (st == MEM_WAIT) begin
      ctrl = CTRL_RUN;
      nxt = RUN;
    end else if (st == FLUSH || bus.ex_branch_taken) begin
      ctrl = CTRL_FLUSH;
      nxt = (st == FLUSH) ? RUN : FLUSH;
    end else if (lu_hazard) begin
      ctrl = CTRL_LU;
      nxt = LU_STALL;
    end
  end
  assign bus.fetch_enable = ctrl.fetch_enable;
  assign bus.decode_enable = ctrl.decode_enable;
  assign bus.decode_stall_control = ctrl.decode_stall_control;
  assign bus.id_flush = ctrl.id_flush;
  assign bus.ex_bubble = ctrl.ex_bubble;
  assign bus.ex_hold = ctrl.ex_hold;
  assign state = st;
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= RUN;
    else st <= nxt;
  // Saturating stall counter; clear wins over increment
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_count <= '0;
    else stall_count <= stall_cnt_clr ? '0 :
                        (ctrl.decode_stall_control && stall_count != '1) ? stall_count + 1'b1 : stall_count;
endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control: directed scoreboard bench for hazard_control
module tb_hazard_control;
  import hazard_control_pkg::*;
  typedef struct packed {
    logic [5:0] c;
    logic [1:0] s;
    logic [1:0] n;
  } exp_t;
  localparam logic [5:0] R = 6'b110000;
  localparam logic [5:0] L = 6'b001010;
  localparam logic [5:0] B = 6'b100110;
  localparam logic [5:0] M = 6'b001001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_cnt_clr = 1'b0;
  logic [1:0] state;
  logic [1:0] stall_count;
  int checks = 0;
  int fails = 0;
  exp_t exp_q[$];
  hazard_control_if bus();
  hazard_control #(.STALL_CNT_W(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_cnt_clr(stall_cnt_clr),
    .state(state), .stall_count(stall_count)
  );
  always #10 clk = ~clk;
  task automatic step(input logic iv, u1, u2, input logic [4:0] r1, r2, input logic ev, ld,
                      input logic [4:0] rd, input logic br, rq, rdy, clr,
                      input logic [5:0] c, input logic [1:0] s, n);
    @(negedge clk);
    bus.id_valid = iv; bus.id_uses_rs1 = u1; bus.id_uses_rs2 = u2;
    bus.id_rs1 = r1; bus.id_rs2 = r2; bus.ex_valid = ev; bus.ex_is_load = ld;
    bus.ex_rd = rd; bus.ex_branch_taken = br; bus.dmem_req = rq; bus.dmem_ready = rdy;
    stall_cnt_clr = clr;
    exp_q.push_back('{c: c, s: s, n: n});
  endtask
  task automatic chk(input string name, input logic [5:0] act, req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ctrl", {bus.fetch_enable, bus.decode_enable, bus.decode_stall_control,
                     bus.id_flush, bus.ex_bubble, bus.ex_hold}, e.c);
        chk("state", {4'b0, state}, {4'b0, e.s});
        chk("stall_count", {4'b0, stall_count}, {4'b0, e.n});
      end
    end
  end
  initial begin
    //   iv u1 u2 rs1 rs2 ev ld rd br rq rdy clr  ctrl st cnt
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   R, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   R, 0, 0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   R, 0, 0);
    step(1, 1, 0, 5, 0, 1, 1, 5, 0, 0, 0, 0,   L, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   R, 1, 1);
    step(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,   R, 0, 1);
    step(1, 0, 1, 3, 7, 1, 1, 7, 0, 0, 0, 0,   L, 0, 1);
    step(1, 0, 1, 3, 7, 1, 1, 7, 0, 0, 0, 0,   L, 1, 2);
    step(1, 0, 1, 3, 7, 1, 1, 7, 0, 0, 0, 0,   L, 1, 3);
    step(1, 0, 1, 3, 7, 1, 1, 7, 0, 0, 0, 1,   L, 1, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   R, 1, 0);
    step(1, 1, 0, 5, 0, 1, 1, 6, 0, 0, 0, 0,   R, 0, 0);
    step(1, 1, 0, 5, 0, 1, 1, 5, 1, 0, 0, 0,   B, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   B, 2, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   R, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,   M, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,   M, 3, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,   M, 3, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0,   R, 3, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   B, 0, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   B, 2, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   R, 0, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   R, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   M, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   M, 3, 1);
    #5;
    rst = 1'b1;
    #2;
    chk("async_rst_state", {4'b0, state}, 6'd0);
    chk("async_rst_count", {4'b0, stall_count}, 6'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   R, 0, 0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   R, 0, 0);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
